// File: rtl/ex_m_elastic.sv
// ex_m_elastic: EX/MEM pipeline stage with a valid/ready handshake, an optional
// one-entry skid buffer and a synchronous flush. All state changes on the
// falling edge of clk, like the rest of the pipeline.
module ex_m_elastic #(
    parameter int pc_size       = 18,
    parameter int data_size     = 32,
    parameter int reg_addr_size = 5,
    parameter bit SKID          = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     EX_valid,
    output logic                     EX_ready,
    input  logic                     EX_MemtoReg,
    input  logic                     EX_RegWrite,
    input  logic                     EX_MemWrite,
    input  logic                     EX_Jal,
    input  logic                     EX_Select,
    input  logic [data_size-1:0]     EX_ALU_result,
    input  logic [data_size-1:0]     EX_Rt_data,
    input  logic [pc_size-1:0]       EX_PCplus8,
    input  logic [reg_addr_size-1:0] EX_WR_out,
    input  logic                     flush,
    input  logic                     M_ready,
    output logic                     M_valid,
    output logic                     M_MemtoReg,
    output logic                     M_RegWrite,
    output logic                     M_MemWrite,
    output logic                     M_Jal,
    output logic                     M_Select,
    output logic [data_size-1:0]     M_ALU_result,
    output logic [data_size-1:0]     M_Rt_data,
    output logic [pc_size-1:0]       M_PCplus8,
    output logic [reg_addr_size-1:0] M_WR_out,
    output logic [1:0]               M_occupancy
);

    // One pipeline beat: control bits plus datapath fields.
    typedef struct packed {
        logic                     mem_to_reg;
        logic                     reg_write;
        logic                     mem_write;
        logic                     jal;
        logic                     sel;
        logic [data_size-1:0]     alu_result;
        logic [data_size-1:0]     rt_data;
        logic [pc_size-1:0]       pc_plus8;
        logic [reg_addr_size-1:0] wr_out;
    } beat_t;

    beat_t ex_beat;
    beat_t main_d, main_q;
    beat_t skid_d, skid_q;
    logic  main_full_d, main_full_q;
    logic  skid_full_d, skid_full_q;
    logic  rst_q;
    logic  push, pop;

    assign ex_beat = '{
        mem_to_reg: EX_MemtoReg,
        reg_write:  EX_RegWrite,
        mem_write:  EX_MemWrite,
        jal:        EX_Jal,
        sel:        EX_Select,
        alu_result: EX_ALU_result,
        rt_data:    EX_Rt_data,
        pc_plus8:   EX_PCplus8,
        wr_out:     EX_WR_out
    };

    // A flushed EX beat never enters; a pop in a flush cycle still completes downstream.
    assign push = EX_valid & EX_ready & ~flush;
    assign pop  = main_full_q & M_ready;

    // Next-state for main and skid entries: flush clears, otherwise fill/drain in order.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        main_d      = main_q;
        main_full_d = main_full_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (flush) begin
            main_d      = '0;
            main_full_d = 1'b0;
            skid_d      = '0;
            skid_full_d = 1'b0;
        end else if (skid_full_q) begin
            if (pop) begin
                main_d      = skid_q;
                skid_full_d = 1'b0;
            end
        end else if (main_full_q) begin
            if (pop && push) begin
                main_d = ex_beat;
            end else if (pop) begin
                main_full_d = 1'b0;
            end else if (push) begin
                skid_d      = ex_beat;
                skid_full_d = 1'b1;
            end
        end else if (push) begin
            main_d      = ex_beat;
            main_full_d = 1'b1;
        end
    end

    // Main entry, its valid flag and the delayed reset, all on the falling edge.
    always_ff @(negedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            // NOTE: payload is reset as well because the M_* outputs must read zero after rst.
            main_q      <= '0;
            main_full_q <= 1'b0;
            rst_q       <= 1'b1;
        end else begin
            main_q      <= main_d;
            main_full_q <= main_full_d;
            rst_q       <= 1'b0;
        end
    end

    if (SKID) begin : g_skid
        // Skid entry: absorbs one beat when M_ready drops while EX is still sending.
        always_ff @(negedge clk) begin
            if (rst) begin
                skid_q      <= '0;
                skid_full_q <= 1'b0;
            end else begin
                skid_q      <= skid_d;
                skid_full_q <= skid_full_d;
            end
        end
        // Ready comes from flops only, so it never depends on M_ready in the same cycle.
        assign EX_ready = ~rst & ~rst_q & ~skid_full_q;
    end else begin : g_no_skid
        assign skid_q      = '0;
        assign skid_full_q = 1'b0;
        // Single entry: accept when empty or when the held beat leaves on this edge.
        assign EX_ready    = ~rst & ~rst_q & (~main_full_q | M_ready);
    end

    // Presented beat is always the main entry; write enables are gated so bubbles never write.
    assign M_valid      = main_full_q;
    assign M_MemtoReg   = main_q.mem_to_reg;
    assign M_RegWrite   = main_q.reg_write & main_full_q;
    assign M_MemWrite   = main_q.mem_write & main_full_q;
    assign M_Jal        = main_q.jal;
    assign M_Select     = main_q.sel;
    assign M_ALU_result = main_q.alu_result;
    assign M_Rt_data    = main_q.rt_data;
    assign M_PCplus8    = main_q.pc_plus8;
    assign M_WR_out     = main_q.wr_out;
    assign M_occupancy  = {1'b0, main_full_q} + {1'b0, skid_full_q};

endmodule

// File: doc/ex_m_elastic.md
# ex_m_elastic

Parametrised EX/MEM pipeline stage with a valid/ready handshake, an optional one-entry skid buffer, and a synchronous flush. It sits between the execute stage and the memory stage. It carries the same WB/M control bits and datapath fields as the plain EX/MEM latch. Unlike that latch, it can hold data under back-pressure, insert bubbles, and drop wrong-path instructions without losing or duplicating a beat.

## Interface
- pc_size, 18, width of PCplus8
- data_size, 32, width of ALU_result and Rt_data
- reg_addr_size, 5, width of WR_out
- SKID, 1, 1 = two-entry elastic stage (main + skid, registered ex_ready); 0 = single entry with combinational ex_ready
- clk  in  1  clock; all state updates on the falling edge, as in the rest of the pipeline
- rst  in  1  synchronous, active-high reset, sampled on the falling edge of clk
- EX_valid  in  1  EX beat present
- EX_ready  out  1  stage can accept a beat this cycle
- EX_MemtoReg, EX_RegWrite, EX_MemWrite, EX_Jal, EX_Select  in  1 each  control bits
- EX_ALU_result, EX_Rt_data  in  data_size  datapath
- EX_PCplus8  in  pc_size  return address
- EX_WR_out  in  reg_addr_size  destination register
- flush  in  1  discard every held beat and any beat offered this cycle
- M_ready  in  1  memory stage accepts the presented beat
- M_valid  out  1  beat presented
- M_MemtoReg, M_RegWrite, M_MemWrite, M_Jal, M_Select, M_ALU_result, M_Rt_data, M_PCplus8, M_WR_out  out  as inputs  presented beat
- M_occupancy  out  2  beats held (0..2)

## Operation
- Push = EX_valid & EX_ready & !flush. Pop = M_valid & M_ready.
- Outputs always reflect the main entry. M_valid = main_full.
- M_RegWrite and M_MemWrite are ANDed with M_valid, so a bubble never writes. The other M_* fields hold their last value when the stage is empty.
- SKID=1, next-state per falling edge:
  - empty, push: main <= EX.
  - main only, pop without push: empty.
  - main only, push and pop: main <= EX.
  - main only, push without pop: skid <= EX.
  - main+skid, pop: main <= skid, skid empty.
  - main+skid, no pop: hold.
- SKID=1, ready: EX_ready = !skid_full & !rst_q, registered. It never depends combinationally on M_ready.
- SKID=0: EX_ready = !rst_q & (!main_full | M_ready), combinational. The skid entry is not built. M_occupancy[1] = 0.
- flush (highest priority after rst): main_full and skid_full clear, and all M_* payload registers clear to 0. The EX beat offered in the same cycle is dropped. A pop in the flush cycle still completes downstream, because the beat was presented before the edge.
- rst: all state and outputs clear. rst_q is 1 for the reset cycle, so EX_ready = 0 while rst is high and 1 from the first cycle after rst deasserts.
- Order is preserved: never reorder, duplicate, or drop a beat except on flush or rst.
- M_occupancy = main_full + skid_full.

## Timing
- Latency: a beat pushed at falling edge N is presented (M_valid = 1) from edge N until its pop edge. The minimum is 1 cycle EX→M, identical to the plain latch.
- Throughput: 1 beat/cycle sustained while M_ready = 1.
- SKID=1: a single-cycle M_ready drop absorbs one extra beat. EX_ready falls the cycle after the skid fills and rises the cycle after it drains.
- Reset values: M_valid 0, all M_* 0, M_occupancy 0, EX_ready 0 during rst.
- Reset mid-operation: held beats are lost, no output toggles beyond clearing, and no write is qualified in the reset cycle.

## Test plan
- Reset: hold rst 2 cycles with EX_valid = 1 and ALU_result = 0xDEADBEEF. Required: M_valid = 0, EX_ready = 0, all M_* = 0. One cycle after release, EX_ready = 1.
- Streaming: M_ready = 1, push ALU_result 1..8 on consecutive cycles. Required: M_ALU_result 1..8 on consecutive cycles, M_occupancy ≤ 1, no gaps.
- Back-pressure (SKID=1): push A = 0x10 and B = 0x20, drop M_ready for 3 cycles. Required: occupancy 2, EX_ready = 0, A held. After M_ready = 1: A, then B, then EX_ready = 1.
- Flush with full stage: occupancy 2, then assert flush together with EX_valid (C = 0x30). Required: next cycle occupancy 0, M_valid = 0, M_RegWrite = 0, M_MemWrite = 0, C never appears.
- SKID=0 stall: main full, M_ready = 0. Required: EX_ready = 0 in the same cycle. Raise M_ready: EX_ready = 1 combinationally, and push and pop occur on the same edge.
- Bubble gating: push a beat with EX_RegWrite = 1 and EX_MemWrite = 1, then pop with no new push. Required: M_RegWrite and M_MemWrite fall to 0 with M_valid, while M_WR_out holds its value.
